// File: rtl/uart_dump.sv
// UART upload engine: reads words from instruction memory and sends them
// LSB byte first on uart_tx as 8N1 frames.
module uart_dump #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int UART_BPS     = 19200,
  parameter int BAUD_CNT_MAX = CLK_FREQ / UART_BPS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dump_en_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [15:0] num_words_i,
  output logic        rib_rd_req_o,
  output logic        mem_rd_en_o,
  output logic [31:0] mem_rd_addr_o,
  input  logic [31:0] mem_rd_data_i,
  output logic        uart_tx,
  output logic        busy_o,
  output logic        done_o
);

  localparam int BW = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CNT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP,
    S_NEXT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [1:0]    r_byte;
  logic [15:0]   r_count;
  logic [31:0]   r_addr;
  logic [31:0]   r_word;
  logic          r_zero;
  logic          w_baud_end;
  logic          w_last_word;

  assign w_baud_end  = (r_baud == BAUD_LAST);
  assign w_last_word = (r_count == 16'd1);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start_i && num_words_i != 16'd0) w_next = S_RD;
      S_RD:    w_next = S_WAIT;
      S_WAIT:  w_next = S_START;
      S_START: if (w_baud_end) w_next = S_DATA;
      S_DATA:  if (w_baud_end && r_bit == 3'd7) w_next = S_STOP;
      S_STOP: begin
        if (w_baud_end)
          w_next = (r_byte == 2'd3) ? S_NEXT : S_START;
      end
      S_NEXT:  w_next = w_last_word ? S_IDLE : S_RD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else if (!dump_en_i)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_count <= '0;
      r_addr  <= '0;
      r_word  <= '0;
      r_zero  <= 1'b0;
    end else if (!dump_en_i) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_count <= '0;
      r_addr  <= '0;
      r_word  <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_zero <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_addr  <= base_addr_i & 32'hFFFF_FFFC;
            r_count <= num_words_i;
            r_zero  <= (num_words_i == 16'd0);
          end
        end
        S_WAIT: begin
          r_word <= mem_rd_data_i;
          r_byte <= 2'd0;
          r_bit  <= 3'd0;
          r_baud <= '0;
        end
        S_START: r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
        S_DATA: begin
          r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
          if (w_baud_end) r_bit <= r_bit + 3'd1;
        end
        S_STOP: begin
          r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
          if (w_baud_end && r_byte != 2'd3)
            r_byte <= r_byte + 2'd1;
        end
        S_NEXT: begin
          r_count <= r_count - 16'd1;
          if (!w_last_word) r_addr <= r_addr + 32'd4;
        end
        default: ;
      endcase
    end
  end

  // {byte, bit} selects bit 8*byte+bit of the latched word
  assign uart_tx = (r_state == S_START) ? 1'b0 :
                   (r_state == S_DATA)  ? r_word[{r_byte, r_bit}] :
                   1'b1;

  assign mem_rd_en_o   = (r_state == S_RD);
  assign mem_rd_addr_o = r_addr;
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = dump_en_i &
                         (r_zero | ((r_state == S_NEXT) & w_last_word));
  assign rib_rd_req_o  = busy_o | r_zero;

endmodule

// File: tb/tb_uart_dump.sv
// Bench for uart_dump: per-cycle output model, serial receiver and
// directed scenarios with literal expectations.
module tb_uart_dump;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dump_en_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = 32'h0;
  logic [15:0] num_words_i = 16'h0;
  logic [31:0] mem_rd_data_i = 32'hDEAD_BEEF;
  logic        rib_rd_req_o;
  logic        mem_rd_en_o;
  logic [31:0] mem_rd_addr_o;
  logic        uart_tx;
  logic        busy_o;
  logic        done_o;

  uart_dump #(
    .CLK_FREQ(1_000_000),
    .UART_BPS(100_000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dump_en_i(dump_en_i),
    .start_i(start_i),
    .base_addr_i(base_addr_i),
    .num_words_i(num_words_i),
    .rib_rd_req_o(rib_rd_req_o),
    .mem_rd_en_o(mem_rd_en_o),
    .mem_rd_addr_o(mem_rd_addr_o),
    .mem_rd_data_i(mem_rd_data_i),
    .uart_tx(uart_tx),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        tx;
    logic        rd;
    logic [31:0] addr;
    logic        busy;
    logic        done;
    logic        req;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  rx_q[$];
  logic [31:0] rd_addrs[$];
  int          rd_cyc[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mon_on = 1'b0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h0) ? 32'h1234_5678 : (32'hC0DE_0000 | {16'h0, a[15:0]});
  endfunction

  function automatic exp_t mk(input logic tx, input logic rd,
                              input logic [31:0] addr, input logic busy,
                              input logic done, input logic req);
    exp_t e;
    e.tx = tx; e.rd = rd; e.addr = addr;
    e.busy = busy; e.done = done; e.req = req;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected outputs, one entry per cycle, starting the cycle after accept
  task automatic build(input logic [31:0] base, input logic [15:0] n);
    logic [31:0] a;
    logic [31:0] d;
    logic [9:0]  fr;
    if (n == 16'd0) begin
      q.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1));
      return;
    end
    for (int w = 0; w < int'(n); w++) begin
      a = (base & 32'hFFFF_FFFC) + 32'(4 * w);
      d = mem_f(a);
      q.push_back(mk(1'b1, 1'b1, a, 1'b1, 1'b0, 1'b1));
      q.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1));
      for (int b = 0; b < 4; b++) begin
        fr = {1'b1, d[8*b +: 8], 1'b0};
        for (int s = 0; s < 10; s++)
          repeat (10) q.push_back(mk(fr[s], 1'b0, 32'h0, 1'b1, 1'b0, 1'b1));
      end
      q.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, (w == int'(n) - 1), 1'b1));
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    mem_rd_data_i <= mem_rd_en_o ? mem_f(mem_rd_addr_o) : 32'hDEAD_BEEF;

  always @(negedge clk) begin : cmp
    exp_t e;
    exp_t a;
    if (mem_rd_en_o) begin
      rd_addrs.push_back(mem_rd_addr_o);
      rd_cyc.push_back(cyc);
    end
    if (done_o) done_cnt++;
    if (mon_on) begin
      if (q.size() > 0) e = q.pop_front();
      else e = mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      a = mk(uart_tx, mem_rd_en_o, e.rd ? mem_rd_addr_o : 32'h0,
             busy_o, done_o, rib_rd_req_o);
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs cyc %0d: got tx=%b rd=%b addr=%h busy=%b done=%b req=%b, expected tx=%b rd=%b addr=%h busy=%b done=%b req=%b",
                 cyc, a.tx, a.rd, a.addr, a.busy, a.done, a.req,
                 e.tx, e.rd, e.addr, e.busy, e.done, e.req);
      end
    end
  end

  initial begin : rx
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx === 1'b0) begin
        repeat (4) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (10) @(negedge clk);
          b[k] = uart_tx;
        end
        repeat (10) @(negedge clk);
        chk("rx_stop_bit", {63'h0, uart_tx}, 64'h1);
        rx_q.push_back(b);
      end
    end
  end

  task automatic clear_logs();
    rx_q.delete();
    rd_addrs.delete();
    rd_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [31:0] base, input logic [15:0] n,
                          input bit plan);
    @(posedge clk);
    #1;
    base_addr_i = base;
    num_words_i = n;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    if (plan) build(base, n);
  endtask

  task automatic wait_idle(input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy_o) ok = 1'b1;
    end
    chk("idle_timeout", {63'h0, ok}, 64'h1);
    repeat (20) @(posedge clk);
  endtask

  task automatic check_bytes(input string nm, input logic [7:0] ex[$]);
    chk({nm, "_len"}, rx_q.size(), ex.size());
    for (int i = 0; i < ex.size(); i++)
      chk($sformatf("%s_b%0d", nm, i), rx_q[i], ex[i]);
  endtask

  task automatic model_bytes(input logic [31:0] base, input int n,
                             output logic [7:0] ex[$]);
    logic [31:0] d;
    ex.delete();
    for (int w = 0; w < n; w++) begin
      d = mem_f((base & 32'hFFFF_FFFC) + 32'(4 * w));
      for (int b = 0; b < 4; b++) ex.push_back(d[8*b +: 8]);
    end
  endtask

  initial begin : main
    logic [7:0] ex[$];

    #2;
    chk("rst_tx", {63'h0, uart_tx}, 64'h1);
    chk("rst_ctl", {60'h0, busy_o, rib_rd_req_o, mem_rd_en_o, done_o}, 64'h0);
    chk("rst_addr", mem_rd_addr_o, 64'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_on = 1'b1;
    repeat (5) @(posedge clk);

    // single word, literal byte order
    clear_logs();
    do_start(32'h0, 16'd1, 1'b1);
    wait_idle(600);
    ex = '{8'h78, 8'h56, 8'h34, 8'h12};
    check_bytes("t1", ex);
    chk("t1_rd_cnt", rd_addrs.size(), 64'd1);
    chk("t1_rd_addr", rd_addrs[0], 64'h0);
    chk("t1_done_cnt", done_cnt, 64'd1);

    // three words with inter-word gap
    clear_logs();
    do_start(32'h100, 16'd3, 1'b1);
    wait_idle(1500);
    model_bytes(32'h100, 3, ex);
    check_bytes("t2", ex);
    chk("t2_b4_lit", rx_q[4], 64'h04);
    chk("t2_b5_lit", rx_q[5], 64'h01);
    chk("t2_b7_lit", rx_q[7], 64'hC0);
    chk("t2_rd_addr2", rd_addrs[2], 64'h108);
    chk("t2_word_period0", rd_cyc[1] - rd_cyc[0], 64'd403);
    chk("t2_word_period1", rd_cyc[2] - rd_cyc[1], 64'd403);
    chk("t2_done_cnt", done_cnt, 64'd1);

    // zero words
    clear_logs();
    do_start(32'h40, 16'd0, 1'b1);
    repeat (5) @(posedge clk);
    chk("t3_done_cnt", done_cnt, 64'd1);
    chk("t3_rd_cnt", rd_addrs.size(), 64'd0);
    chk("t3_rx_cnt", rx_q.size(), 64'd0);

    // abort mid bit 3 of byte 2, then restart
    clear_logs();
    do_start(32'h0, 16'd1, 1'b1);
    repeat (247) @(posedge clk);
    #1 dump_en_i = 1'b0;
    q = q[0:0];
    @(negedge clk);
    chk("t4_pre_abort_tx", {63'h0, uart_tx}, 64'h0);
    @(negedge clk);
    chk("t4_post_abort", {60'h0, uart_tx, busy_o, rib_rd_req_o, done_o}, 64'h8);
    repeat (5) @(posedge clk);
    #1 dump_en_i = 1'b1;
    repeat (120) @(posedge clk);
    chk("t4_no_done", done_cnt, 64'd0);
    clear_logs();
    do_start(32'h0, 16'd1, 1'b1);
    wait_idle(600);
    ex = '{8'h78, 8'h56, 8'h34, 8'h12};
    check_bytes("t4r", ex);
    chk("t4r_rd_addr", rd_addrs[0], 64'h0);
    chk("t4r_done_cnt", done_cnt, 64'd1);

    // start while busy is ignored
    clear_logs();
    do_start(32'h200, 16'd2, 1'b1);
    repeat (50) @(posedge clk);
    do_start(32'h9000, 16'd7, 1'b0);
    wait_idle(1200);
    model_bytes(32'h200, 2, ex);
    check_bytes("t5", ex);
    chk("t5_rd_cnt", rd_addrs.size(), 64'd2);
    chk("t5_rd_addr0", rd_addrs[0], 64'h200);
    chk("t5_rd_addr1", rd_addrs[1], 64'h204);
    chk("t5_done_cnt", done_cnt, 64'd1);

    // start while disabled is ignored
    clear_logs();
    dump_en_i = 1'b0;
    do_start(32'h500, 16'd1, 1'b0);
    repeat (3) @(posedge clk);
    #1 dump_en_i = 1'b1;
    repeat (20) @(posedge clk);
    chk("t5d_done_cnt", done_cnt, 64'd0);
    chk("t5d_rd_cnt", rd_addrs.size(), 64'd0);
    chk("t5d_rx_cnt", rx_q.size(), 64'd0);

    // unaligned base forced to word, address wraps
    clear_logs();
    do_start(32'hFFFF_FFFF, 16'd2, 1'b1);
    wait_idle(1200);
    ex = '{8'hFC, 8'hFF, 8'hDE, 8'hC0, 8'h78, 8'h56, 8'h34, 8'h12};
    check_bytes("t6", ex);
    chk("t6_rd_addr0", rd_addrs[0], 64'hFFFF_FFFC);
    chk("t6_rd_addr1", rd_addrs[1], 64'h0);

    // asynchronous reset mid transfer
    clear_logs();
    do_start(32'h300, 16'd2, 1'b1);
    repeat (150) @(posedge clk);
    #1;
    chk("t7_pre_rst_tx", {63'h0, uart_tx}, 64'h0);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("t7_rst_tx", {63'h0, uart_tx}, 64'h1);
    chk("t7_rst_ctl", {60'h0, busy_o, rib_rd_req_o, mem_rd_en_o, done_o}, 64'h0);
    chk("t7_rst_addr", mem_rd_addr_o, 64'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (120) @(posedge clk);
    chk("t7_no_done", done_cnt, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
